// File: rtl/mips_regfile_scrub.sv
// NRD-port register file: zero-latency reads, byte-enabled writes, and a DEPTH-1 cycle zeroing sweep (Busy).
// Writes during the sweep are dropped and flagged by Wr_Drop. Define MIPS_REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module mips_regfile_scrub #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NRD*ADDR_W-1:0] R_Addr,
  output logic [NRD*DATA_W-1:0] R_Data,
  input  logic [ADDR_W-1:0]     W_Addr,
  input  logic [DATA_W-1:0]     W_Data,
  input  logic [DATA_W/8-1:0]   W_Byte_En,
  input  logic                  Write_Reg,
  input  logic                  Clr_Req,
  output logic                  Busy,
  output logic                  Wr_Drop
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   sweep_cnt;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic                wr_hit;
  logic [DATA_W-1:0]   wr_merged;

  // Register 0 is never stored to; its reads are forced to zero below.
  assign wr_hit = Write_Reg && (W_Addr != '0);

  always_comb begin
    wr_merged = regs[W_Addr];
    for (int i = 0; i < NB; i++) begin
      if (W_Byte_En[i]) wr_merged[8*i +: 8] = W_Data[8*i +: 8];
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= CLEAR;
      sweep_cnt <= ADDR_W'(1);
      Busy      <= 1'b1;
      Wr_Drop   <= 1'b0;
    end else begin
      Wr_Drop <= Busy && wr_hit;
      case (state)
        IDLE: begin
          if (Clr_Req) begin
            state     <= CLEAR;
            sweep_cnt <= ADDR_W'(1);
            Busy      <= 1'b1;
          end
        end
        CLEAR: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Storage has no reset; the sweep is the only way it gets cleared.
  always_ff @(posedge Clk) begin
    if (Busy) begin
      regs[sweep_cnt] <= '0;
    end else if (wr_hit) begin
      regs[W_Addr] <= wr_merged;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    R_Data = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = R_Addr[k*ADDR_W +: ADDR_W];
      if (!Busy && ra != '0) begin
`ifdef MIPS_REGFILE_BYPASS_EN
        if (wr_hit && ra == W_Addr) R_Data[k*DATA_W +: DATA_W] = wr_merged;
        else                        R_Data[k*DATA_W +: DATA_W] = regs[ra];
`else
        R_Data[k*DATA_W +: DATA_W] = regs[ra];
`endif
      end
    end
  end

endmodule
